// File: rtl/vreg_wb_sched.sv
// vreg_wb_sched: write-back scheduler and scoreboard for the 8 x 256-bit
// vector register file. Round-robin arbitration of the single write port
// between the vector ALU and the vector load unit, plus a busy bit per
// register that issue uses for hazard detection and destination claims.
// Optional build macro VRF_WB_FWD_EN: treat the register being written this
// cycle as already free for hazard checks and claims.
module vreg_wb_sched (
    input  logic         clk,
    input  logic         rst,
    input  logic         claim_en_i,
    input  logic [2:0]   claim_dst_i,
    output logic         claim_ack_o,
    input  logic [2:0]   rd_addr_1_i,
    input  logic [2:0]   rd_addr_2_i,
    output logic         hazard_o,
    output logic [7:0]   busy_o,
    input  logic         alu_req_i,
    input  logic [2:0]   alu_dst_i,
    input  logic [255:0] alu_data_i,
    output logic         alu_gnt_o,
    input  logic         ld_req_i,
    input  logic [2:0]   ld_dst_i,
    input  logic [255:0] ld_data_i,
    output logic         ld_gnt_o,
    output logic         wr_en_o,
    output logic [2:0]   wr_dst_o,
    output logic [255:0] wr_data_o,
    output logic         wb_err_o
);

    // Which requester won the most recent grant.
    typedef enum logic {
        LAST_ALU = 1'b0,
        LAST_LD  = 1'b1
    } last_e;

    last_e          last_q, last_d;
    logic [7:0]     busy_q, busy_d;
    logic           wr_en_q, wr_en_d;
    logic [2:0]     wr_dst_q, wr_dst_d;
    logic [255:0]   wr_data_q, wr_data_d;
    logic           wb_err_q, wb_err_d;

    logic           fwd_c, fwd_1, fwd_2;
    logic           alu_gnt, ld_gnt;

    // A write landing at the coming edge frees its register early when
    // forwarding is built in; otherwise only the scoreboard counts.
`ifdef VRF_WB_FWD_EN
    assign fwd_c = wr_en_q && (wr_dst_q == claim_dst_i);
    assign fwd_1 = wr_en_q && (wr_dst_q == rd_addr_1_i);
    assign fwd_2 = wr_en_q && (wr_dst_q == rd_addr_2_i);
`else
    assign fwd_c = 1'b0;
    assign fwd_1 = 1'b0;
    assign fwd_2 = 1'b0;
`endif

    // Issue-side views: claim acceptance and source hazards.
    always_comb begin
        claim_ack_o = claim_en_i && (!busy_q[claim_dst_i] || fwd_c);
        hazard_o    = (busy_q[rd_addr_1_i] && !fwd_1) ||
                      (busy_q[rd_addr_2_i] && !fwd_2);
    end

    // Round-robin grant: a lone requester always wins; on a tie the unit
    // not granted last wins.
    always_comb begin
        alu_gnt = alu_req_i && (!ld_req_i || (last_q == LAST_LD));
        ld_gnt  = ld_req_i  && (!alu_req_i || (last_q == LAST_ALU));
    end

    // Next state: scoreboard clear then claim (claim wins on the same
    // register), write-port capture, pointer update and sticky error.
    always_comb begin
        busy_d    = busy_q;
        last_d    = last_q;
        wr_en_d   = 1'b0;
        wr_dst_d  = wr_dst_q;
        wr_data_d = wr_data_q;
        wb_err_d  = wb_err_q;

        if (wr_en_q) begin
            if (!busy_q[wr_dst_q]) begin
                wb_err_d = 1'b1;
            end
            busy_d[wr_dst_q] = 1'b0;
        end
        if (claim_ack_o) begin
            busy_d[claim_dst_i] = 1'b1;
        end

        if (alu_gnt) begin
            wr_en_d   = 1'b1;
            wr_dst_d  = alu_dst_i;
            wr_data_d = alu_data_i;
            last_d    = LAST_ALU;
        end else if (ld_gnt) begin
            wr_en_d   = 1'b1;
            wr_dst_d  = ld_dst_i;
            wr_data_d = ld_data_i;
            last_d    = LAST_LD;
        end
    end

    // State registers; reset drops any grant made in the reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= LAST_LD;
            busy_q    <= 8'h00;
            wr_en_q   <= 1'b0;
            wr_dst_q  <= 3'd0;
            wr_data_q <= 256'd0;
            wb_err_q  <= 1'b0;
        end else begin
            last_q    <= last_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_dst_q  <= wr_dst_d;
            wr_data_q <= wr_data_d;
            wb_err_q  <= wb_err_d;
        end
    end

    // Output wiring.
    always_comb begin
        alu_gnt_o = alu_gnt;
        ld_gnt_o  = ld_gnt;
        busy_o    = busy_q;
        wr_en_o   = wr_en_q;
        wr_dst_o  = wr_dst_q;
        wr_data_o = wr_data_q;
        wb_err_o  = wb_err_q;
    end

endmodule
